accelerator_matrix_stream_driver: RTL and testbench

- Transmitter side of the accelerator two-level enable/data streaming protocol.
- Holds an I x J matrix in an internal buffer that software loads over a simple write port.
- On START, streams the matrix row-major into a consumer such as the accelerator controller's W/K/U input ports. Uses row/element enables and waits for the consumer's per-element and per-row acknowledges.
- Used in place of the stimulus model to feed weights into the LSTM controller in system-level benches and in the MPSoC integration.

---
 rtl/accelerator_matrix_stream_driver_if.sv | 31 +++
 rtl/accelerator_matrix_stream_driver.sv | 125 ++++++++++++
 tb/tb_accelerator_matrix_stream_driver.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_matrix_stream_driver_if.sv
// rtl/accelerator_matrix_stream_driver_if.sv - load, control and row/element stream signals of the matrix stream driver
interface accelerator_matrix_stream_driver_if #(
  parameter int DATA_SIZE    = 64,
  parameter int ADDRESS_SIZE = 12
);
  logic                    load_enable;
  logic [ADDRESS_SIZE-1:0] load_address;
  logic [DATA_SIZE-1:0]    load_data;
  logic                    start;
  logic                    ready;
  logic                    error;
  logic [DATA_SIZE-1:0]    size_i_in;
  logic [DATA_SIZE-1:0]    size_j_in;
  logic [DATA_SIZE-1:0]    data_out;
  logic                    data_i_enable;
  logic                    data_j_enable;
  logic                    data_out_i_enable;
  logic                    data_out_j_enable;

  modport master (
    input  load_enable, load_address, load_data, start, size_i_in, size_j_in,
           data_out_i_enable, data_out_j_enable,
    output ready, error, data_out, data_i_enable, data_j_enable
  );

  modport slave (
    output load_enable, load_address, load_data, start, size_i_in, size_j_in,
           data_out_i_enable, data_out_j_enable,
    input  ready, error, data_out, data_i_enable, data_j_enable
  );
endinterface

// File: rtl/accelerator_matrix_stream_driver.sv
// rtl/accelerator_matrix_stream_driver.sv - buffers an I x J matrix and streams it row-major
// over the two-level row/element enable protocol, waiting for consumer acknowledges.
module accelerator_matrix_stream_driver #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4,
  parameter int ADDRESS_SIZE = 12
) (
  input logic                                clk,
  input logic                                rst,
  accelerator_matrix_stream_driver_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam int PW    = 2 * DATA_SIZE;

  // CONTROL_SIZE only keeps the parameter list aligned with sibling stream blocks
  if (CONTROL_SIZE > 0) begin : g_control_size_unused
  end

  logic [2:0]              state;
  logic [DATA_SIZE-1:0]    size_i;
  logic [DATA_SIZE-1:0]    size_j;
  logic [DATA_SIZE-1:0]    i;
  logic [DATA_SIZE-1:0]    j;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0]    data_q;
  logic                    error_q;
  logic [DATA_SIZE-1:0]    mem [DEPTH];

  logic [PW-1:0] product;
  logic [PW-1:0] depth;
  logic          last_j;
  logic          last_i;

  assign product = {{DATA_SIZE{1'b0}}, size_i} * {{DATA_SIZE{1'b0}}, size_j};
  assign depth   = PW'(1) << ADDRESS_SIZE;
  assign last_j  = (j == size_j - 1'b1);
  assign last_i  = (i == size_i - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      size_i  <= '0;
      size_j  <= '0;
      i       <= '0;
      j       <= '0;
      addr    <= '0;
      error_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            size_i  <= bus.size_i_in;
            size_j  <= bus.size_j_in;
            error_q <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (size_i == '0 || size_j == '0) begin
            state <= DONE;
          end else if (product > depth) begin
            error_q <= 1'b1;
            state   <= DONE;
          end else begin
            i     <= '0;
            j     <= '0;
            addr  <= '0;
            state <= FETCH;
          end
        end
        FETCH: state <= SEND;
        SEND:  state <= WAIT;
        WAIT: begin
          // a row end only completes on the row acknowledge, the element acknowledge alone stalls
          if (!last_j) begin
            if (bus.data_out_j_enable) begin
              j     <= j + 1'b1;
              addr  <= addr + 1'b1;
              state <= FETCH;
            end
          end else if (bus.data_out_i_enable) begin
            if (!last_i) begin
              j     <= '0;
              i     <= i + 1'b1;
              addr  <= addr + 1'b1;
              state <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bus.load_enable && state == IDLE) begin
      mem[bus.load_address] <= bus.load_data;
    end
  end

  // the synchronous read register doubles as the held DATA_OUT value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (state == FETCH) begin
      data_q <= mem[addr];
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_j_enable = (state == SEND);
  assign bus.data_i_enable = (state == SEND) && (j == '0);
  assign bus.ready         = (state == DONE);
  assign bus.error         = error_q;
endmodule

// File: tb/tb_accelerator_matrix_stream_driver.sv
// tb/tb_accelerator_matrix_stream_driver.sv - scoreboard bench for the matrix stream driver
module tb_accelerator_matrix_stream_driver;
  localparam int DATA_SIZE    = 64;
  localparam int CONTROL_SIZE = 4;
  localparam int ADDRESS_SIZE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accelerator_matrix_stream_driver_if #(.DATA_SIZE(DATA_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) bus ();

  accelerator_matrix_stream_driver #(
    .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        i_en;
    int          cyc;
  } elem_t;

  typedef struct {
    logic err;
    int   cyc;
  } rdy_t;

  elem_t elem_q[$];
  rdy_t  rdy_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  int cons_size_j  = 3;
  int cons_elem    = 0;
  int stall_elem   = -1;
  int stall_cycles = 0;
  int halt_elem    = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops an expectation whenever the DUT presents an element or a READY pulse
  initial begin
    elem_t e;
    rdy_t  r;
    forever begin
      @(negedge clk);
      if (bus.data_j_enable) begin
        if (elem_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_send: data %0d at cycle %0d, no element expected", bus.data_out, cyc);
        end else begin
          e = elem_q.pop_front();
          check("data_out", bus.data_out, e.data);
          check("data_i_enable", 64'(bus.data_i_enable), 64'(e.i_en));
          check("send_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (bus.ready) begin
        if (rdy_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: READY at cycle %0d, no completion expected", cyc);
        end else begin
          r = rdy_q.pop_front();
          check("ready_error", 64'(bus.error), 64'(r.err));
          check("ready_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  // consumer: acknowledges in the WAIT cycle right after each SEND
  initial begin
    int  e;
    bit  row_end;
    bus.data_out_i_enable = 1'b0;
    bus.data_out_j_enable = 1'b0;
    forever begin
      @(negedge clk);
      bus.data_out_i_enable = 1'b0;
      bus.data_out_j_enable = 1'b0;
      if (!rst && bus.data_j_enable) begin
        e = cons_elem;
        cons_elem++;
        row_end = ((e % cons_size_j) == cons_size_j - 1);
        @(negedge clk);
        if (e != halt_elem) begin
          if (row_end) begin
            if (e == stall_elem) begin
              for (int k = 0; k < stall_cycles; k++) begin
                bus.data_out_j_enable = 1'b1;
                check("stall_data_out", bus.data_out, 64'(e));
                check("stall_no_send", 64'(bus.data_j_enable), 64'd0);
                @(negedge clk);
              end
              bus.data_out_j_enable = 1'b0;
            end
            bus.data_out_i_enable = 1'b1;
          end else begin
            bus.data_out_j_enable = 1'b1;
          end
        end
      end
    end
  end

  task automatic start_xfer(input logic [63:0] si, input logic [63:0] sj, output int t0);
    @(negedge clk);
    bus.size_i_in = si;
    bus.size_j_in = sj;
    bus.start     = 1'b1;
    t0            = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // buffer holds mem[a] = a, so element n of a stream carries value n
  task automatic expect_stream(input int t0, input int si, input int sj, input int st_e, input int st_n);
    elem_t e;
    rdy_t  r;
    int    t;
    t = t0 + 3;
    for (int n = 0; n < si * sj; n++) begin
      e.data = 64'(n);
      e.i_en = ((n % sj) == 0);
      e.cyc  = t;
      elem_q.push_back(e);
      t += 3;
      if (n == st_e) t += st_n;
    end
    r.err = 1'b0;
    r.cyc = t - 1;
    rdy_q.push_back(r);
  endtask

  task automatic expect_reject(input int t0, input logic err);
    rdy_t r;
    r.err = err;
    r.cyc = t0 + 2;
    rdy_q.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((elem_q.size() != 0 || rdy_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d elements and %0d READY pulses outstanding, expected 0",
               name, elem_q.size(), rdy_q.size());
      elem_q.delete();
      rdy_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_normal(input int si, input int sj, input string name);
    int t0;
    cons_size_j = sj;
    cons_elem   = 0;
    start_xfer(64'(si), 64'(sj), t0);
    expect_stream(t0, si, sj, -1, 0);
    wait_idle(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    bus.load_enable  = 1'b0;
    bus.load_address = '0;
    bus.load_data    = '0;
    bus.start        = 1'b0;
    bus.size_i_in    = '0;
    bus.size_j_in    = '0;

    repeat (2) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_error", 64'(bus.error), 64'd0);
    check("reset_data_out", bus.data_out, 64'd0);
    check("reset_i_enable", 64'(bus.data_i_enable), 64'd0);
    check("reset_j_enable", 64'(bus.data_j_enable), 64'd0);
    rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      bus.load_enable  = 1'b1;
      bus.load_address = ADDRESS_SIZE'(a);
      bus.load_data    = 64'(a);
    end
    @(negedge clk);
    bus.load_enable = 1'b0;

    // 1: 2x3 with prompt acknowledges
    run_normal(2, 3, "case1");

    // 2: row-end stall with element acknowledge only
    cons_size_j  = 3;
    cons_elem    = 0;
    stall_elem   = 2;
    stall_cycles = 5;
    start_xfer(64'd2, 64'd3, t0);
    expect_stream(t0, 2, 3, 2, 5);
    wait_idle("case2");
    stall_elem = -1;

    // 3: zero size
    start_xfer(64'd0, 64'd5, t0);
    expect_reject(t0, 1'b0);
    wait_idle("case3");

    // 4: oversized 5x4 > 16, then a valid START clears ERROR
    start_xfer(64'd5, 64'd4, t0);
    expect_reject(t0, 1'b1);
    wait_idle("case4");
    check("error_sticky", 64'(bus.error), 64'd1);
    cons_size_j = 3;
    cons_elem   = 0;
    start_xfer(64'd2, 64'd3, t0);
    check("error_cleared", 64'(bus.error), 64'd0);
    expect_stream(t0, 2, 3, -1, 0);
    wait_idle("case4b");

    // boundary: 4x4 exactly fills the buffer
    run_normal(4, 4, "full_buffer");

    // 5: reset during WAIT of element 2
    cons_size_j = 3;
    cons_elem   = 0;
    halt_elem   = 2;
    start_xfer(64'd2, 64'd3, t0);
    expect_stream(t0, 2, 3, -1, 0);
    while (cyc < t0 + 10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_data_out", bus.data_out, 64'd0);
    check("abort_i_enable", 64'(bus.data_i_enable), 64'd0);
    check("abort_j_enable", 64'(bus.data_j_enable), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd0);
    check("abort_error", 64'(bus.error), 64'd0);
    check("abort_pending_elems", 64'(elem_q.size()), 64'd3);
    elem_q.delete();
    rdy_q.delete();
    halt_elem = -1;
    cons_elem = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_normal(2, 3, "case5_rerun");

    // 6: LOAD and START pulsed mid-transfer are ignored
    cons_size_j = 3;
    cons_elem   = 0;
    start_xfer(64'd2, 64'd3, t0);
    expect_stream(t0, 2, 3, -1, 0);
    while (cyc < t0 + 4) @(negedge clk);
    bus.load_enable  = 1'b1;
    bus.load_address = '0;
    bus.load_data    = 64'd99;
    bus.start        = 1'b1;
    bus.size_i_in    = 64'd1;
    bus.size_j_in    = 64'd1;
    @(negedge clk);
    bus.load_enable = 1'b0;
    bus.start       = 1'b0;
    wait_idle("case6");
    repeat (10) @(negedge clk);
    run_normal(2, 3, "case6_rerun");
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
